// File: rtl/sensor_scan_ctrl.sv
// Time-multiplexed scanner for NUM_GROUPS 4-bit sensor groups on one shared bus.
// Selects a group, waits SETTLE cycles, samples it, debounces errors, raises a sticky alarm.
//   clk/n_rst    : clock, asynchronous active-low reset
//   enable       : 1 = scan runs, 0 = scan pauses in IDLE
//   sensors      : muxed sensor group selected by group_sel
//   ack          : alarm acknowledge pulse
//   group_sel    : group index to the external mux
//   err_vec      : debounced error status, one bit per group
//   alarm        : sticky alarm, alarm_group = group that raised it
//   scan_done    : one-cycle pulse after the last group is sampled
module sensor_scan_ctrl #(
    parameter int NUM_GROUPS = 4,
    parameter int SETTLE     = 2,
    parameter int DEBOUNCE   = 3,
    localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  enable,
    input  logic [3:0]            sensors,
    input  logic                  ack,
    output logic [GW-1:0]         group_sel,
    output logic [NUM_GROUPS-1:0] err_vec,
    output logic                  alarm,
    output logic [GW-1:0]         alarm_group,
    output logic                  scan_done
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [CW-1:0] CNT_SAT     = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_ARM     = CW'(DEBOUNCE - 1);
    localparam logic [GW-1:0] LAST_GRP    = GW'(NUM_GROUPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE
    } state_t;

    state_t        r_state;
    logic [SW-1:0] r_settle_cnt;
    logic [CW-1:0] r_cnt [NUM_GROUPS];

    logic w_err;
    logic w_sat;
    logic w_arm;

    assign w_err = sensors[0] | (sensors[1] & (sensors[2] | sensors[3]));
    assign w_sat = (r_cnt[group_sel] == CNT_SAT);
    // Alarm event: the counter of the sampled group steps onto saturation.
    assign w_arm = (r_state == ST_SAMPLE) && w_err
                   && (r_cnt[group_sel] == CNT_ARM);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
            group_sel    <= '0;
            err_vec      <= '0;
            alarm        <= 1'b0;
            alarm_group  <= '0;
            scan_done    <= 1'b0;
            for (int i = 0; i < NUM_GROUPS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            scan_done <= 1'b0;

            // A new event overrides an ack arriving in the same cycle.
            if (w_arm) begin
                alarm <= 1'b1;
                if (!alarm || ack) begin
                    alarm_group <= group_sel;
                end
            end else if (ack) begin
                alarm <= 1'b0;
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state      <= ST_SETTLE;
                        r_settle_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                    end else if (r_settle_cnt == SETTLE_LAST) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (w_err) begin
                        if (!w_sat) begin
                            r_cnt[group_sel] <= r_cnt[group_sel] + 1'b1;
                        end
                        if (w_arm) begin
                            err_vec[group_sel] <= 1'b1;
                        end
                    end else begin
                        r_cnt[group_sel]   <= '0;
                        err_vec[group_sel] <= 1'b0;
                    end
                    scan_done    <= (group_sel == LAST_GRP);
                    group_sel    <= (group_sel == LAST_GRP) ? '0
                                    : group_sel + 1'b1;
                    r_settle_cnt <= '0;
                    r_state      <= enable ? ST_SETTLE : ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
